// File: rtl/spi_adc_responder.sv
`default_nettype none
// ============================================================================
// Module   : spi_adc_responder
// Purpose  : SPI responder that emulates an ADCS7476-style 12-bit ADC,
//            including the power-down/power-up frame protocol.
// Revision : 1.0
// ============================================================================
module spi_adc_responder #(
    parameter int DATA_BITS    = 12,
    parameter int LEAD_ZEROS   = 4,
    parameter int SYNC_STAGES  = 2,
    parameter int PD_MIN_EDGES = 2,
    parameter int PD_MAX_EDGES = 10
) (
    input  logic                 sysclk,
    input  logic                 rst_n,
    input  logic                 spi_sclk,
    input  logic                 spi_cs_n,
    output logic                 spi_sdata_o,
    output logic                 spi_sdata_t,
    input  logic [DATA_BITS-1:0] sample_data,
    input  logic                 sample_valid,
    output logic                 powered_up,
    output logic                 frame_done,
    output logic                 frame_data_valid,
    output logic [4:0]           frame_edges,
    output logic                 pd_entered,
    output logic                 stale
);

    localparam int FRAME_BITS = LEAD_ZEROS + DATA_BITS;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_TAIL  = 2'd2
    } state_t;

    logic [SYNC_STAGES-1:0] r_sclk_sync;
    logic [SYNC_STAGES-1:0] r_cs_sync;
    logic                   r_sclk_d;
    logic                   r_cs_d;
    logic [SYNC_STAGES:0]   r_settle;
    logic                   r_armed;

    state_t                 r_state;
    logic [FRAME_BITS-1:0]  r_shift;
    logic [4:0]             r_edges;
    logic                   r_fdv_next;
    logic [DATA_BITS-1:0]   r_hold;
    logic                   r_fresh;

    logic                   w_sclk_fall;
    logic                   w_cs_fall;
    logic                   w_cs_rise;
    logic [FRAME_BITS-1:0]  w_frame_word;

    assign w_sclk_fall  = r_sclk_d & ~r_sclk_sync[SYNC_STAGES-1];
    assign w_cs_fall    = r_cs_d & ~r_cs_sync[SYNC_STAGES-1];
    assign w_cs_rise    = ~r_cs_d & r_cs_sync[SYNC_STAGES-1];
    assign w_frame_word = powered_up ? {{LEAD_ZEROS{1'b0}}, r_hold} : '0;

    // Synchronizers reset high, so arming waits until the chain has flushed
    // real pin samples; otherwise a CS_N held low through reset looks like a fall.
    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_sclk_sync <= '1;
            r_cs_sync   <= '1;
            r_sclk_d    <= 1'b1;
            r_cs_d      <= 1'b1;
            r_settle    <= '0;
            r_armed     <= 1'b0;
        end else begin
            r_sclk_sync <= {r_sclk_sync[SYNC_STAGES-2:0], spi_sclk};
            r_cs_sync   <= {r_cs_sync[SYNC_STAGES-2:0], spi_cs_n};
            r_sclk_d    <= r_sclk_sync[SYNC_STAGES-1];
            r_cs_d      <= r_cs_sync[SYNC_STAGES-1];
            r_settle    <= {r_settle[SYNC_STAGES-1:0], 1'b1};
            if (r_settle[SYNC_STAGES] && r_cs_sync[SYNC_STAGES-1])
                r_armed <= 1'b1;
        end
    end

    always_ff @(posedge sysclk or negedge rst_n) begin
        if (!rst_n) begin
            r_state          <= ST_IDLE;
            r_shift          <= '0;
            r_edges          <= '0;
            r_fdv_next       <= 1'b0;
            r_hold           <= '0;
            r_fresh          <= 1'b0;
            spi_sdata_o      <= 1'b0;
            spi_sdata_t      <= 1'b1;
            powered_up       <= 1'b0;
            frame_done       <= 1'b0;
            frame_data_valid <= 1'b0;
            frame_edges      <= '0;
            pd_entered       <= 1'b0;
            stale            <= 1'b0;
        end else begin
            frame_done <= 1'b0;
            pd_entered <= 1'b0;
            stale      <= 1'b0;

            if (sample_valid) begin
                r_hold  <= sample_data;
                r_fresh <= 1'b1;
            end

            case (r_state)
                ST_IDLE: begin
                    if (r_armed && w_cs_fall) begin
                        r_state     <= ST_SHIFT;
                        r_shift     <= w_frame_word;
                        r_fdv_next  <= powered_up;
                        r_edges     <= '0;
                        spi_sdata_o <= w_frame_word[FRAME_BITS-1];
                        spi_sdata_t <= 1'b0;
                        stale       <= ~r_fresh;
                        if (!sample_valid)
                            r_fresh <= 1'b0;
                    end
                end
                ST_SHIFT, ST_TAIL: begin
                    if (w_cs_rise) begin
                        r_state     <= ST_IDLE;
                        spi_sdata_o <= 1'b0;
                        spi_sdata_t <= 1'b1;
                        frame_done  <= 1'b1;
                        frame_edges <= r_edges;
                        // Short frames never deliver a complete sample.
                        if (r_edges >= 5'(PD_MAX_EDGES)) begin
                            if (!powered_up) begin
                                powered_up       <= 1'b1;
                                frame_data_valid <= 1'b0;
                            end else begin
                                frame_data_valid <= r_fdv_next;
                            end
                        end else begin
                            frame_data_valid <= 1'b0;
                            if (r_edges >= 5'(PD_MIN_EDGES) && powered_up) begin
                                powered_up <= 1'b0;
                                pd_entered <= 1'b1;
                            end
                        end
                    end else if (w_sclk_fall) begin
                        if (r_edges != 5'(FRAME_BITS))
                            r_edges <= r_edges + 5'd1;
                        if (r_state == ST_SHIFT) begin
                            if (r_edges < 5'(FRAME_BITS - 1)) begin
                                r_shift     <= r_shift << 1;
                                spi_sdata_o <= r_shift[FRAME_BITS-2];
                            end else begin
                                spi_sdata_o <= 1'b0;
                                spi_sdata_t <= 1'b1;
                                r_state     <= ST_TAIL;
                            end
                        end
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

endmodule
`default_nettype wire
